// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a framed program image, writes it into instruction
// memory word by word and releases the core once length and checksum have been verified.
module uart_boot_loader #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              uart_txd_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned TimerW     = $clog2(ClksPerBit + 1);
  localparam logic [TimerW-1:0] BitEnd  = TimerW'(ClksPerBit - 1);
  localparam logic [TimerW-1:0] HalfEnd = TimerW'(ClksPerBit / 2 - 1);
  localparam logic [16:0] MemWords = 17'(MEM_WORDS);
  localparam logic [7:0]  Magic    = 8'hB0;

  typedef enum logic [1:0] {StRxIdle, StRxStart, StRxData, StRxStop} rx_state_e;
  typedef enum logic [2:0] {
    StWaitMagic, StLenLo, StLenHi, StData, StCsum, StDone, StError
  } frame_state_e;

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rx_state_q, rx_state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_vld_q, byte_vld_d;
  logic              rx_err_q, rx_err_d;

  frame_state_e      frame_q, frame_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, boot_done_q, boot_err_q;

  // Byte receiver; shift_q holds the assembled byte while byte_vld_q is high.
  always_comb begin
    rx_state_d = rx_state_q;
    timer_d    = timer_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    rx_err_d   = 1'b0;
    unique case (rx_state_q)
      StRxIdle: begin
        timer_d = '0;
        if (!rx_sync_q) rx_state_d = StRxStart;
      end
      StRxStart: begin
        if (timer_q == HalfEnd) begin
          timer_d    = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? StRxIdle : StRxData;
        end
      end
      StRxData: begin
        if (timer_q == BitEnd) begin
          timer_d   = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = StRxStop;
        end
      end
      StRxStop: begin
        if (timer_q == BitEnd) begin
          timer_d    = '0;
          byte_vld_d = rx_sync_q;
          rx_err_d   = !rx_sync_q;
          rx_state_d = StRxIdle;
        end
      end
      default: rx_state_d = StRxIdle;
    endcase
  end

  // Frame parser and memory write port.
  always_comb begin
    frame_d     = frame_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    csum_d      = csum_q;
    wbuf_d      = wbuf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // A completed boot is final; a framing error anywhere else aborts the load.
    if (rx_err_q && frame_q != StDone) begin
      frame_d = StError;
    end else if (byte_vld_q) begin
      unique case (frame_q)
        StWaitMagic: if (shift_q == Magic) frame_d = StLenLo;
        StLenLo: begin
          len_d[7:0] = shift_q;
          frame_d    = StLenHi;
        end
        StLenHi: begin
          len_d[15:8] = shift_q;
          if ({shift_q, len_q[7:0]} == 16'd0 || {1'b0, shift_q, len_q[7:0]} > MemWords) begin
            frame_d = StError;
          end else begin
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            frame_d    = StData;
          end
        end
        StData: begin
          csum_d     = csum_q ^ shift_q;
          wbuf_d     = {shift_q, wbuf_q[23:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = {shift_q, wbuf_q};
            word_cnt_d  = word_cnt_q + 1'b1;
            if (17'(word_cnt_q) == 17'(len_q) - 17'd1) frame_d = StCsum;
          end
        end
        StCsum: frame_d = (shift_q == csum_q) ? StDone : StError;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= StRxIdle;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      frame_q     <= StWaitMagic;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      csum_q      <= '0;
      wbuf_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      rx_meta_q   <= uart_txd_in;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      rx_err_q    <= rx_err_d;
      frame_q     <= frame_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      csum_q      <= csum_d;
      wbuf_q      <= wbuf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= (frame_d != StDone);
      boot_done_q <= (frame_d == StDone);
      boot_err_q  <= (frame_d == StError);
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign boot_done = boot_done_q;
  assign boot_err  = boot_err_q;

endmodule
